// File: rtl/bus_arbiter_if.sv
// Groups the CPU, DMA and external memory bus signals of the two-requester bus arbiter.
// Latency: none (wires only).
// Backpressure: requesters are held off through the ack/stall signals carried here.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    // CPU requester
    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;
    // DMA requester
    logic                  dma_read;
    logic                  dma_write;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_ack;
    // External memory bus
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic                  busy;

    // Requesters and memory model side
    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output dma_read, dma_write, dma_addr, dma_wdata,
        output bus_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall, dma_rdata, dma_ack,
        input  bus_addr, bus_wdata, mem_read, mem_write, busy
    );

    // Arbiter side
    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  dma_read, dma_write, dma_addr, dma_wdata,
        input  bus_rdata,
        output cpu_rdata, cpu_ack, cpu_stall, dma_rdata, dma_ack,
        output bus_addr, bus_wdata, mem_read, mem_write, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Arbitrates CPU and DMA accesses onto one external memory bus, alternating grants on a tie.
// Latency: strobe for WAIT_CYCLES+1 cycles starting the cycle after the request, ack in the last one.
// Backpressure: cpu_stall holds the CPU until its ack; an IDLE turnaround cycle follows every access.
module bus_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_t;

    localparam logic [3:0] WAIT_INIT    = 4'(WAIT_CYCLES);
    // With no wait cycles the entry cycle is also the final cycle, so ack is set on entry.
    localparam logic       ACK_ON_ENTRY = (WAIT_CYCLES == 0);

    state_t                state_q, state_d;
    grant_t                last_grant_q, last_grant_d;
    logic [3:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  busy_q, busy_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  dma_ack_q, dma_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic cpu_req;
    logic dma_req;
    logic grant_cpu;
    logic grant_dma;

    assign cpu_req   = bif.cpu_read | bif.cpu_write;
    assign dma_req   = bif.dma_read | bif.dma_write;
    // On a tie the requester that was not served last wins.
    assign grant_cpu = cpu_req & (~dma_req | (last_grant_q == GNT_DMA));
    assign grant_dma = dma_req & ~grant_cpu;

    // Next-state, captured request and registered bus outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        busy_d       = busy_q;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        case (state_q)
            IDLE: begin
                addr_d      = '0;
                wdata_d     = '0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
                if (grant_cpu) begin
                    state_d      = CPU_ACC;
                    last_grant_d = GNT_CPU;
                    wait_d       = WAIT_INIT;
                    addr_d       = bif.cpu_addr;
                    wdata_d      = bif.cpu_wdata;
                    mem_write_d  = bif.cpu_write;
                    mem_read_d   = ~bif.cpu_write;
                    busy_d       = 1'b1;
                    cpu_ack_d    = ACK_ON_ENTRY;
                end else if (grant_dma) begin
                    state_d      = DMA_ACC;
                    last_grant_d = GNT_DMA;
                    wait_d       = WAIT_INIT;
                    addr_d       = bif.dma_addr;
                    wdata_d      = bif.dma_wdata;
                    mem_write_d  = bif.dma_write;
                    mem_read_d   = ~bif.dma_write;
                    busy_d       = 1'b1;
                    dma_ack_d    = ACK_ON_ENTRY;
                end
            end

            CPU_ACC, DMA_ACC: begin
                if (wait_q == 4'd0) begin
                    // Final cycle: return to IDLE for turnaround, latch read data.
                    state_d     = IDLE;
                    addr_d      = '0;
                    wdata_d     = '0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    busy_d      = 1'b0;
                    if (mem_read_q) begin
                        if (state_q == CPU_ACC) begin
                            cpu_rdata_d = bif.bus_rdata;
                        end else begin
                            dma_rdata_d = bif.bus_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                    // Next cycle is the final one, so the ack is registered now.
                    if (wait_q == 4'd1) begin
                        cpu_ack_d = (state_q == CPU_ACC);
                        dma_ack_d = (state_q == DMA_ACC);
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                addr_d      = '0;
                wdata_d     = '0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DMA;
            wait_q       <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            busy_q       <= busy_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bif.bus_addr  = addr_q;
    assign bif.bus_wdata = wdata_q;
    assign bif.mem_read  = mem_read_q;
    assign bif.mem_write = mem_write_q;
    assign bif.busy      = busy_q;
    assign bif.cpu_ack   = cpu_ack_q;
    assign bif.dma_ack   = dma_ack_q;
    assign bif.cpu_rdata = cpu_rdata_q;
    assign bif.dma_rdata = dma_rdata_q;
    // Combinational so the pipeline is released in the ack cycle itself.
    assign bif.cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle vector table on a WAIT_CYCLES=2 instance,
// plus a hand-written sequence on a WAIT_CYCLES=0 instance.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bif2 ();
    bus_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bif0 ();

    bus_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bif   (bif2.slave)
    );

    bus_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bif   (bif0.slave)
    );

    typedef struct packed {
        logic        rst;
        logic        crd;
        logic        cwr;
        logic [19:0] caddr;
        logic [15:0] cwd;
        logic        drd;
        logic        dwr;
        logic [19:0] daddr;
        logic [15:0] dwd;
        logic [15:0] brd;
    } stim_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [19:0] addr;
        logic [15:0] wd;
        logic        cack;
        logic        dack;
        logic        stall;
        logic        busy;
        logic [15:0] crd;
        logic [15:0] drd;
    } resp_t;

    typedef struct packed {
        stim_t stim;
        logic  chk;
        resp_t resp;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic stim_t si(input logic rst, crd, cwr, input logic [19:0] caddr,
                                 input logic [15:0] cwd, input logic drd, dwr,
                                 input logic [19:0] daddr, input logic [15:0] dwd, brd);
        si = '{rst, crd, cwr, caddr, cwd, drd, dwr, daddr, dwd, brd};
    endfunction

    function automatic resp_t ro(input logic rd, wr, input logic [19:0] addr,
                                 input logic [15:0] wd, input logic cack, dack, stall, busy,
                                 input logic [15:0] crd, drd);
        ro = '{rd, wr, addr, wd, cack, dack, stall, busy, crd, drd};
    endfunction

    function automatic resp_t idle(input logic stall, input logic [15:0] crd, drd);
        idle = ro(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b0, stall, 1'b0, crd, drd);
    endfunction

    task automatic add(input stim_t s, input logic c, input resp_t r);
        vt.push_back('{s, c, r});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive2(input stim_t s);
        reset           = s.rst;
        bif2.cpu_read   = s.crd;
        bif2.cpu_write  = s.cwr;
        bif2.cpu_addr   = s.caddr;
        bif2.cpu_wdata  = s.cwd;
        bif2.dma_read   = s.drd;
        bif2.dma_write  = s.dwr;
        bif2.dma_addr   = s.daddr;
        bif2.dma_wdata  = s.dwd;
        bif2.bus_rdata  = s.brd;
    endtask

    task automatic compare2(input int idx, input resp_t e);
        chk($sformatf("v%0d mem_read", idx),  32'(bif2.mem_read),  32'(e.rd));
        chk($sformatf("v%0d mem_write", idx), 32'(bif2.mem_write), 32'(e.wr));
        chk($sformatf("v%0d bus_addr", idx),  32'(bif2.bus_addr),  32'(e.addr));
        chk($sformatf("v%0d bus_wdata", idx), 32'(bif2.bus_wdata), 32'(e.wd));
        chk($sformatf("v%0d cpu_ack", idx),   32'(bif2.cpu_ack),   32'(e.cack));
        chk($sformatf("v%0d dma_ack", idx),   32'(bif2.dma_ack),   32'(e.dack));
        chk($sformatf("v%0d cpu_stall", idx), 32'(bif2.cpu_stall), 32'(e.stall));
        chk($sformatf("v%0d busy", idx),      32'(bif2.busy),      32'(e.busy));
        chk($sformatf("v%0d cpu_rdata", idx), 32'(bif2.cpu_rdata), 32'(e.crd));
        chk($sformatf("v%0d dma_rdata", idx), 32'(bif2.dma_rdata), 32'(e.drd));
    endtask

    // Watchdog: the run is fixed-length, so this only fires if time stops advancing sensibly.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t rst_s, zero_s, a_s, a_off, b_s, c0_s, c1_s, c2_s, c3_s, d_s, d_r;
        resp_t cw_o, cw_ack, dw_o, dw_ack, rd_o, w_o;
        vec_t  cur;

        rst_s  = si(1, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0, 16'h0);
        zero_s = si(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0, 16'h0);

        // CPU read held, WAIT_CYCLES=2: strobe c1-3, ack c3, stall c0-2, rdata from c4.
        a_s   = si(0, 1, 0, 20'h00010, 16'h0, 0, 0, 20'h0, 16'h0, 16'hBEEF);
        a_off = si(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0, 16'h1234);
        add(rst_s, 0, idle(0, 16'h0, 16'h0));
        add(a_s, 1, idle(1, 16'h0, 16'h0));
        add(a_s, 1, ro(1, 0, 20'h00010, 16'h0, 0, 0, 1, 1, 16'h0, 16'h0));
        add(a_s, 1, ro(1, 0, 20'h00010, 16'h0, 0, 0, 1, 1, 16'h0, 16'h0));
        add(a_s, 1, ro(1, 0, 20'h00010, 16'h0, 1, 0, 0, 1, 16'h0, 16'h0));
        add(a_off, 1, idle(0, 16'hBEEF, 16'h0));
        add(a_off, 1, idle(0, 16'hBEEF, 16'h0));

        // Both writes held from reset: CPU first, then alternate with one IDLE between.
        b_s    = si(0, 0, 1, 20'h00100, 16'h1111, 0, 1, 20'h80000, 16'h2222, 16'h0);
        cw_o   = ro(0, 1, 20'h00100, 16'h1111, 0, 0, 1, 1, 16'h0, 16'h0);
        cw_ack = ro(0, 1, 20'h00100, 16'h1111, 1, 0, 0, 1, 16'h0, 16'h0);
        dw_o   = ro(0, 1, 20'h80000, 16'h2222, 0, 0, 1, 1, 16'h0, 16'h0);
        dw_ack = ro(0, 1, 20'h80000, 16'h2222, 0, 1, 1, 1, 16'h0, 16'h0);
        add(rst_s, 0, idle(0, 16'h0, 16'h0));
        add(b_s, 1, idle(1, 16'h0, 16'h0));
        for (int r = 0; r < 2; r++) begin
            add(b_s, 1, cw_o);
            add(b_s, 1, cw_o);
            add(b_s, 1, cw_ack);
            add(b_s, 1, idle(1, 16'h0, 16'h0));
            add(b_s, 1, dw_o);
            add(b_s, 1, dw_o);
            add(b_s, 1, dw_ack);
            if (r == 0) add(b_s, 1, idle(1, 16'h0, 16'h0));
        end
        add(zero_s, 1, idle(0, 16'h0, 16'h0));

        // DMA read; dma_addr changes mid-access and the request drops before the ack.
        c0_s = si(0, 0, 0, 20'h0, 16'h0, 1, 0, 20'h80000, 16'h0, 16'hCAFE);
        c1_s = si(0, 0, 0, 20'h0, 16'h0, 1, 0, 20'h80004, 16'h0, 16'hCAFE);
        c2_s = si(0, 0, 0, 20'h0, 16'h0, 0, 0, 20'h80004, 16'h0, 16'hCAFE);
        c3_s = zero_s;
        rd_o = ro(1, 0, 20'h80000, 16'h0, 0, 0, 0, 1, 16'h0, 16'h0);
        add(rst_s, 0, idle(0, 16'h0, 16'h0));
        add(c0_s, 1, idle(0, 16'h0, 16'h0));
        add(c0_s, 1, rd_o);
        add(c1_s, 1, rd_o);
        add(c2_s, 1, ro(1, 0, 20'h80000, 16'h0, 0, 1, 0, 1, 16'h0, 16'h0));
        add(c3_s, 1, idle(0, 16'h0, 16'hCAFE));

        // Reset during cycle 2 of a CPU write: strobe gone at c3, no ack, re-grant after.
        d_s = si(0, 0, 1, 20'h00200, 16'h3333, 0, 0, 20'h0, 16'h0, 16'h0);
        d_r = si(1, 0, 1, 20'h00200, 16'h3333, 0, 0, 20'h0, 16'h0, 16'h0);
        w_o = ro(0, 1, 20'h00200, 16'h3333, 0, 0, 1, 1, 16'h0, 16'h0);
        add(rst_s, 0, idle(0, 16'h0, 16'h0));
        add(d_s, 1, idle(1, 16'h0, 16'h0));
        add(d_s, 1, w_o);
        add(d_r, 1, w_o);
        add(d_s, 1, idle(1, 16'h0, 16'h0));
        add(d_s, 1, w_o);
        add(d_s, 1, w_o);
        add(d_s, 1, ro(0, 1, 20'h00200, 16'h3333, 1, 0, 0, 1, 16'h0, 16'h0));
        add(zero_s, 1, idle(0, 16'h0, 16'h0));

        drive2(zero_s);
        bif0.cpu_read  = 1'b0;
        bif0.cpu_write = 1'b0;
        bif0.cpu_addr  = '0;
        bif0.cpu_wdata = '0;
        bif0.dma_read  = 1'b0;
        bif0.dma_write = 1'b0;
        bif0.dma_addr  = '0;
        bif0.dma_wdata = '0;
        bif0.bus_rdata = '0;

        // Table run: expected response queued when the stimulus goes in, popped at sample time.
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            drive2(vt[i].stim);
            sb.push_back(vt[i]);
            @(negedge clk);
            cur = sb.pop_front();
            if (cur.chk) compare2(i, cur.resp);
        end

        // WAIT_CYCLES=0 instance: single-cycle accesses.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bif0.cpu_read  = 1'b1;
        bif0.cpu_addr  = 20'h00040;
        bif0.bus_rdata = 16'h5A5A;
        @(negedge clk);                                   // c0
        chk("w0 c0 mem_read", 32'(bif0.mem_read), 32'd0);
        chk("w0 c0 cpu_stall", 32'(bif0.cpu_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);                                   // c1: strobe and ack together
        chk("w0 c1 mem_read", 32'(bif0.mem_read), 32'd1);
        chk("w0 c1 cpu_ack", 32'(bif0.cpu_ack), 32'd1);
        chk("w0 c1 busy", 32'(bif0.busy), 32'd1);
        chk("w0 c1 bus_addr", 32'(bif0.bus_addr), 32'h40);
        chk("w0 c1 cpu_stall", 32'(bif0.cpu_stall), 32'd0);
        @(posedge clk); #1;
        bif0.cpu_read = 1'b0;
        @(negedge clk);                                   // c2: turnaround
        chk("w0 c2 mem_read", 32'(bif0.mem_read), 32'd0);
        chk("w0 c2 cpu_ack", 32'(bif0.cpu_ack), 32'd0);
        chk("w0 c2 busy", 32'(bif0.busy), 32'd0);
        chk("w0 c2 cpu_rdata", 32'(bif0.cpu_rdata), 32'h5A5A);

        // Tie after a CPU grant: DMA goes first, CPU after one turnaround cycle.
        @(posedge clk); #1;
        bif0.cpu_write = 1'b1;
        bif0.cpu_addr  = 20'h00041;
        bif0.cpu_wdata = 16'h0A0A;
        bif0.dma_write = 1'b1;
        bif0.dma_addr  = 20'h00042;
        bif0.dma_wdata = 16'h0B0B;
        @(negedge clk);                                   // c3
        chk("w0 c3 busy", 32'(bif0.busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);                                   // c4: DMA
        chk("w0 c4 mem_write", 32'(bif0.mem_write), 32'd1);
        chk("w0 c4 bus_addr", 32'(bif0.bus_addr), 32'h42);
        chk("w0 c4 dma_ack", 32'(bif0.dma_ack), 32'd1);
        chk("w0 c4 cpu_ack", 32'(bif0.cpu_ack), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);                                   // c5: turnaround
        chk("w0 c5 mem_write", 32'(bif0.mem_write), 32'd0);
        chk("w0 c5 busy", 32'(bif0.busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);                                   // c6: CPU
        chk("w0 c6 bus_addr", 32'(bif0.bus_addr), 32'h41);
        chk("w0 c6 bus_wdata", 32'(bif0.bus_wdata), 32'h0A0A);
        chk("w0 c6 cpu_ack", 32'(bif0.cpu_ack), 32'd1);
        chk("w0 c6 dma_ack", 32'(bif0.dma_ack), 32'd0);
        @(posedge clk); #1;
        bif0.cpu_write = 1'b0;
        bif0.dma_write = 1'b0;
        @(negedge clk);                                   // c7
        chk("w0 c7 mem_write", 32'(bif0.mem_write), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);                                   // c8: nothing requested
        chk("w0 c8 busy", 32'(bif0.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, the external bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the external bus data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, the number of extra bus cycles per access (range 0..15).
REQ-004 SHALL have one clock and a synchronous active-high reset, on ports clk and reset.
REQ-005 SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have ports cpu_read and cpu_write, input, 1 bit each: the CPU memory-stage access request.
REQ-008 SHALL have ports cpu_addr (input, ADDR_WIDTH), cpu_wdata (input, DATA_WIDTH) and cpu_rdata (output, DATA_WIDTH).
REQ-009 SHALL have ports cpu_ack (output, 1 bit: CPU access complete) and cpu_stall (output, 1 bit: freeze the CPU pipeline).
REQ-010 SHALL have ports dma_read and dma_write, input, 1 bit each: the secondary requester's access request.
REQ-011 SHALL have ports dma_addr, dma_wdata, dma_rdata and dma_ack, with the same widths and meanings as the cpu_ ports.
REQ-012 SHALL have ports bus_addr (output, ADDR_WIDTH), bus_wdata (output, DATA_WIDTH) and bus_rdata (input, DATA_WIDTH).
REQ-013 SHALL have ports mem_read and mem_write, output, 1 bit each: the bus strobes.
REQ-014 SHALL have port busy, output, 1 bit: the bus is in an access state.

Function
REQ-015 SHALL implement the FSM states IDLE, CPU_ACC and DMA_ACC.
REQ-016 SHALL treat a requester as requesting when its read or write input is high; if read and write are both high, write wins.
REQ-017 SHALL arbitrate in IDLE: one requester -> grant it; both -> grant the requester not recorded in last_grant.
REQ-018 SHALL update last_grant on entry to an access state.
REQ-019 SHALL, on every IDLE -> X_ACC transition, register the granted requester's addr, wdata and direction; later changes to those inputs are ignored until the next grant.
REQ-020 SHALL keep each access state for exactly WAIT_CYCLES+1 cycles, counted by a 4-bit wait counter loaded on entry.
REQ-021 SHALL drive bus_addr, bus_wdata and the matching strobe from the registered values for every cycle of an access.
REQ-022 SHALL hold mem_read=mem_write=0, and bus_addr and bus_wdata at 0, in IDLE.
REQ-023 SHALL pulse X_ack for exactly one cycle, the final cycle of the access.
REQ-024 SHALL, on a read, capture bus_rdata into X_rdata at the clock edge ending that final cycle, and hold it until the next read by the same requester.
REQ-025 SHALL always return from an access state to IDLE for one bus-turnaround cycle.
REQ-026 SHALL therefore give an uncontended request presented in IDLE at cycle 0: strobe in cycles 1..1+WAIT_CYCLES, ack in cycle 1+WAIT_CYCLES, rdata valid from cycle 2+WAIT_CYCLES.
REQ-027 SHALL compute cpu_stall = (cpu_read | cpu_write) & ~cpu_ack, combinationally.
REQ-028 SHALL let an access that has started complete, with its ack, even if the request is dropped mid-access.
REQ-029 SHALL start a new access, after the turnaround cycle, if a request is still held after its ack.
REQ-030 SHALL assert busy exactly when the state is CPU_ACC or DMA_ACC.
REQ-031 SHALL, when both requesters hold continuously, alternate grants, bounding either requester's wait to one access plus two turnaround cycles.

Reset
REQ-032 SHALL, while reset is high at a clock edge, go to IDLE and clear the wait counter; last_grant is set to DMA so that the CPU wins the first tie.
REQ-033 SHALL, while reset is high at a clock edge, clear the registered addr, wdata and direction, and clear cpu_rdata and dma_rdata to 0.
REQ-034 SHALL, after a reset edge, hold all outputs at 0 except cpu_stall, which follows REQ-027.
REQ-035 SHALL, if reset is asserted mid-access, drop the strobes from the next cycle and produce no ack for the aborted access.

Verification
REQ-036 SHALL cover: with WAIT_CYCLES=2, CPU read of 0x00010 held, bus_rdata=0xBEEF -> mem_read in cycles 1-3, cpu_ack in cycle 3, cpu_stall high in cycles 0-2, cpu_rdata=0xBEEF from cycle 4.
REQ-037 SHALL cover: CPU and DMA writes both requested from reset -> CPU granted first, DMA's mem_write starts in cycle 5, with one IDLE cycle between the accesses.
REQ-038 SHALL cover: continuous CPU and DMA requests for 4 accesses -> grant order CPU, DMA, CPU, DMA, with no requester served twice in a row.
REQ-039 SHALL cover: dma_addr changed from 0x80000 to 0x80004 during a DMA access -> bus_addr stays 0x80000 for the whole access.
REQ-040 SHALL cover: reset pulsed in cycle 2 of a CPU write -> mem_write=0 from cycle 3, cpu_ack never pulses, and a held request is re-granted after reset.
REQ-041 SHALL cover: with WAIT_CYCLES=0, a single-cycle access -> strobe and ack both in cycle 1 only.
